// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS32 multi-cycle control sequencer.
// Optional ADDI support is built only when MC_ADDI_EN is defined.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_FETCH   = 4'd1,
    ST_DECODE  = 4'd2,
    ST_MEMADR  = 4'd3,
    ST_MEMRD   = 4'd4,
    ST_MEMWB   = 4'd5,
    ST_MEMWR   = 4'd6,
    ST_EXEC    = 4'd7,
    ST_RWB     = 4'd8,
    ST_BRANCH  = 4'd9,
    ST_JUMP    = 4'd10,
`ifdef MC_ADDI_EN
    ST_TRAP    = 4'd12,
    ST_ADDI_EX = 4'd13,
    ST_ADDI_WB = 4'd14
`else
    ST_TRAP    = 4'd12
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALUB_RT     = 2'b00;
  localparam logic [1:0] ALUB_FOUR   = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // Registered per-state strobes; ir_we and the ack/zero-gated pc_we live in the top.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem2reg;
    logic       reg_we;
  } ctrl_t;

  function automatic ctrl_t ctrl_decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      ST_FETCH: begin
        c.mem_req   = 1'b1;
        c.alu_src_b = ALUB_FOUR;
      end
      ST_DECODE: c.alu_src_b = ALUB_IMM_SH;
      ST_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = ALUB_IMM;
      end
      ST_MEMRD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      ST_MEMWB: begin
        c.mem2reg = 1'b1;
        c.reg_we  = 1'b1;
      end
      ST_MEMWR: begin
        c.mem_req = 1'b1;
        c.mem_we  = 1'b1;
        c.iord    = 1'b1;
      end
      ST_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = ALUB_RT;
        c.alu_op    = ALUOP_FUNCT;
      end
      ST_RWB: begin
        c.reg_dst = 1'b1;
        c.reg_we  = 1'b1;
      end
      ST_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = ALUB_RT;
        c.alu_op    = ALUOP_SUB;
        c.pc_src    = PCSRC_BRANCH;
      end
      ST_JUMP: begin
        c.pc_src = PCSRC_JUMP;
        c.pc_we  = 1'b1;
      end
`ifdef MC_ADDI_EN
      ST_ADDI_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = ALUB_IMM;
      end
      ST_ADDI_WB: c.reg_we = 1'b1;
`endif
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic is_mem_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait timer: counts unacknowledged request cycles and flags expiry
// on the last permitted cycle so the sequencer can trap instead of waiting.
module mc_wait_timer #(
  parameter int TIMEOUT_CYC = 16,
  parameter int TW          = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_expire
);

  logic [TW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  // An ack on this cycle drops i_inc, so a late-but-in-time ack never expires.
  assign o_expire = i_inc && (r_count == TW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS32 control sequencer (lw, sw, R-type, beq, j; addi with MC_ADDI_EN).
// Illegal opcodes and memory timeouts park the machine in a sticky trap.
module mc_ctrl_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int TW          = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_dst,
  output logic       mem2reg,
  output logic       reg_we,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [3:0] state_o
);

  state_t     r_state;
  state_t     w_next;
  ctrl_t      r_ctrl;
  logic       r_trap;
  logic [1:0] r_cause;
  logic [1:0] w_cause;
  logic       w_expire;
  logic       w_inc;
  logic       w_clear;
  logic       w_in_fetch;
  logic       w_in_branch;

  always_comb begin
    w_next  = r_state;
    w_cause = CAUSE_NONE;
    case (r_state)
      ST_IDLE:   w_next = ST_FETCH;
      ST_FETCH: begin
        if (mem_ack) begin
          w_next = ST_DECODE;
        end else if (w_expire) begin
          w_next  = ST_TRAP;
          w_cause = CAUSE_TIMEOUT;
        end
      end
      ST_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next = ST_MEMADR;
          OP_RTYPE:     w_next = ST_EXEC;
          OP_BEQ:       w_next = ST_BRANCH;
          OP_J:         w_next = ST_JUMP;
`ifdef MC_ADDI_EN
          OP_ADDI:      w_next = ST_ADDI_EX;
`endif
          default: begin
            w_next  = ST_TRAP;
            w_cause = CAUSE_ILLEGAL;
          end
        endcase
      end
      ST_MEMADR: w_next = (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD: begin
        if (mem_ack) begin
          w_next = ST_MEMWB;
        end else if (w_expire) begin
          w_next  = ST_TRAP;
          w_cause = CAUSE_TIMEOUT;
        end
      end
      ST_MEMWB:  w_next = ST_FETCH;
      ST_MEMWR: begin
        if (mem_ack) begin
          w_next = ST_FETCH;
        end else if (w_expire) begin
          w_next  = ST_TRAP;
          w_cause = CAUSE_TIMEOUT;
        end
      end
      ST_EXEC:   w_next = ST_RWB;
      ST_RWB:    w_next = ST_FETCH;
      ST_BRANCH: w_next = ST_FETCH;
      ST_JUMP:   w_next = ST_FETCH;
`ifdef MC_ADDI_EN
      ST_ADDI_EX: w_next = ST_ADDI_WB;
      ST_ADDI_WB: w_next = ST_FETCH;
`endif
      ST_TRAP:   w_next = ST_TRAP;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Strobes are registered against the next state so they line up with r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ctrl  <= '0;
      r_trap  <= 1'b0;
      r_cause <= CAUSE_NONE;
    end else begin
      r_state <= w_next;
      r_ctrl  <= ctrl_decode(w_next);
      r_trap  <= r_trap | (w_next == ST_TRAP);
      if (w_cause != CAUSE_NONE) begin
        r_cause <= w_cause;
      end
    end
  end

  assign w_inc   = r_ctrl.mem_req & ~mem_ack;
  assign w_clear = mem_ack | (is_mem_state(w_next) && (w_next != r_state));

  mc_wait_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TW         (TW)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_clear),
    .i_inc   (w_inc),
    .o_expire(w_expire)
  );

  assign w_in_fetch  = (r_state == ST_FETCH);
  assign w_in_branch = (r_state == ST_BRANCH);

  assign mem_req    = r_ctrl.mem_req;
  assign mem_we     = r_ctrl.mem_we;
  assign iord       = r_ctrl.iord;
  assign ir_we      = w_in_fetch & mem_ack;
  assign pc_we      = r_ctrl.pc_we | (w_in_fetch & mem_ack) | (w_in_branch & zero);
  assign pc_src     = r_ctrl.pc_src;
  assign alu_src_a  = r_ctrl.alu_src_a;
  assign alu_src_b  = r_ctrl.alu_src_b;
  assign alu_op     = r_ctrl.alu_op;
  assign reg_dst    = r_ctrl.reg_dst;
  assign mem2reg    = r_ctrl.mem2reg;
  assign reg_we     = r_ctrl.reg_we;
  assign trap       = r_trap;
  assign trap_cause = r_cause;
  assign state_o    = r_state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized bench for mc_ctrl_fsm against an instruction-sequence reference model.
// Build with MC_ADDI_EN defined to exercise the optional addi path.
module tb_mc_ctrl_fsm;

  localparam int TIMEOUT_CYC = 16;
  localparam int TW          = 5;

  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEMADR = 3, S_MEMRD = 4;
  localparam int S_MEMWB = 5, S_MEMWR = 6, S_EXEC = 7, S_RWB = 8, S_BRANCH = 9;
  localparam int S_JUMP = 10, S_TRAP = 12, S_ADDI_EX = 13, S_ADDI_WB = 14;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ack;
  logic       mem_req, mem_we, iord, ir_we, pc_we, alu_src_a, reg_dst, mem2reg, reg_we, trap;
  logic [1:0] pc_src, alu_src_b, alu_op, trap_cause;
  logic [3:0] state_o;
  logic [14:0] got_vec;

  mc_ctrl_fsm #(.TIMEOUT_CYC(TIMEOUT_CYC), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_dst(reg_dst), .mem2reg(mem2reg), .reg_we(reg_we), .trap(trap),
    .trap_cause(trap_cause), .state_o(state_o)
  );

  assign got_vec = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a,
                    alu_src_b, alu_op, reg_dst, mem2reg, reg_we};

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [14:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Strobe table per instruction phase, packed in got_vec order.
  function automatic logic [14:0] exp_ctrl(input int st, input logic ack, input logic z);
    logic req, we, ia, irw, pcw, asel, rd, m2r, rw;
    logic [1:0] pcs, bsel, aop;
    {req, we, ia, irw, pcw, asel, rd, m2r, rw} = '0;
    pcs = 2'b00; bsel = 2'b00; aop = 2'b00;
    case (st)
      S_FETCH:   begin req = 1; irw = ack; pcw = ack; bsel = 2'b01; end
      S_DECODE:  bsel = 2'b11;
      S_MEMADR:  begin asel = 1; bsel = 2'b10; end
      S_MEMRD:   begin req = 1; ia = 1; end
      S_MEMWB:   begin m2r = 1; rw = 1; end
      S_MEMWR:   begin req = 1; we = 1; ia = 1; end
      S_EXEC:    begin asel = 1; aop = 2'b10; end
      S_RWB:     begin rd = 1; rw = 1; end
      S_BRANCH:  begin asel = 1; aop = 2'b01; pcs = 2'b01; pcw = z; end
      S_JUMP:    begin pcs = 2'b10; pcw = 1; end
      S_ADDI_EX: begin asel = 1; bsel = 2'b10; end
      S_ADDI_WB: rw = 1;
      default:   ;
    endcase
    return {req, we, ia, irw, pcw, pcs, asel, bsel, aop, rd, m2r, rw};
  endfunction

  // ---------------- reference model ----------------
  int m_state, m_wait, m_dly, m_cause, trap_cycles;
  int m_seq[$];
  logic [5:0] op_q[$];
  int dly_q[$];

  function automatic logic is_mem(input int st);
    return st == S_FETCH || st == S_MEMRD || st == S_MEMWR;
  endfunction

  task automatic pick_delay(output int d);
    int r;
    if (dly_q.size() > 0) begin
      d = dly_q.pop_front();
    end else begin
      r = $urandom_range(0, 19);
      if (r < 12)       d = 0;
      else if (r < 17)  d = $urandom_range(1, 4);
      else if (r == 17) d = TIMEOUT_CYC - 1;
      else if (r == 18) d = TIMEOUT_CYC - 2;
      else              d = TIMEOUT_CYC;
    end
  endtask

  task automatic pick_op(output logic [5:0] op);
    int r;
    if (op_q.size() > 0) begin
      op = op_q.pop_front();
    end else begin
      r = $urandom_range(0, 15);
      case (r)
        0, 1, 2:  op = 6'h23;
        3, 4, 14: op = 6'h2B;
        5, 6, 13: op = 6'h00;
        7, 8, 15: op = 6'h04;
        9:        op = 6'h02;
        10:       op = 6'h08;
        11:       op = 6'h3F;
        default:  op = 6'($urandom_range(0, 63));
      endcase
    end
  endtask

  task automatic next_in_seq(output int ns);
    if (m_seq.size() == 0) ns = S_FETCH;
    else ns = m_seq.pop_front();
  endtask

  task automatic model_update(input logic ack);
    int ns;
    logic [5:0] op;
    ns = m_state;
    case (m_state)
      S_IDLE: ns = S_FETCH;
      S_FETCH, S_MEMRD, S_MEMWR: begin
        if (ack) begin
          if (m_state == S_FETCH) ns = S_DECODE;
          else next_in_seq(ns);
        end else begin
          m_wait++;
          if (m_wait >= TIMEOUT_CYC) begin
            ns = S_TRAP;
            m_cause = 2;
          end
        end
      end
      S_DECODE: begin
        m_seq.delete();
        case (opcode)
          6'h23: m_seq = '{S_MEMADR, S_MEMRD, S_MEMWB};
          6'h2B: m_seq = '{S_MEMADR, S_MEMWR};
          6'h00: m_seq = '{S_EXEC, S_RWB};
          6'h04: m_seq = '{S_BRANCH};
          6'h02: m_seq = '{S_JUMP};
`ifdef MC_ADDI_EN
          6'h08: m_seq = '{S_ADDI_EX, S_ADDI_WB};
`endif
          default: ;
        endcase
        if (m_seq.size() == 0) begin
          ns = S_TRAP;
          m_cause = 1;
        end else begin
          ns = m_seq.pop_front();
        end
      end
      S_TRAP: ns = S_TRAP;
      default: next_in_seq(ns);
    endcase
    if (is_mem(ns) && ns != m_state) begin
      m_wait = 0;
      pick_delay(m_dly);
      if (ns == S_FETCH) begin
        pick_op(op);
        opcode = op;
      end
    end
    m_state = ns;
    trap_cycles = (m_state == S_TRAP) ? trap_cycles + 1 : 0;
  endtask

  task automatic model_reset();
    m_state = S_IDLE;
    m_wait = 0;
    m_dly = 0;
    m_cause = 0;
    trap_cycles = 0;
    m_seq.delete();
  endtask

  // ---------------- driver ----------------
  task automatic check_outputs();
    exp_q.push_back(exp_ctrl(m_state, mem_ack, zero));
    chk("ctrl", 32'(got_vec), 32'(exp_q.pop_front()));
    chk("state", 32'(state_o), m_state);
    chk("trap", 32'(trap), 32'(m_state == S_TRAP));
    chk("cause", 32'(trap_cause), m_cause);
  endtask

  task automatic run_cycle();
    if (trap_cycles >= 4 || (m_state != S_IDLE && $urandom_range(0, 79) == 0)) begin
      rst_n = 1'b0;
      model_reset();
      #1;
      check_outputs();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      return;
    end
    zero = 1'($urandom_range(0, 1));
    if (is_mem(m_state)) mem_ack = (m_wait >= m_dly);
    else mem_ack = 1'($urandom_range(0, 1));
    #1;
    check_outputs();
    @(posedge clk);
    model_update(mem_ack);
    @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    opcode  = 6'h00;
    zero    = 1'b0;
    mem_ack = 1'b0;
    model_reset();
    // Directed opening: lw, beq x2, sw with 3-cycle wait, j, R, lw with ack on
    // the expiry cycle, addi, then a fetch that times out.
    op_q  = '{6'h23, 6'h04, 6'h04, 6'h2B, 6'h02, 6'h00, 6'h23, 6'h08, 6'h23};
    dly_q = '{0, 0, 0, 0, 0, 3, 0, 0, TIMEOUT_CYC - 1, 0, 0, TIMEOUT_CYC};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    repeat (4000) run_cycle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
